tdm_digit_demux: RTL and testbench

Receive-side counterpart of the digit-select multiplexing path. It accepts a time-division-multiplexed stream of digit values, one channel per beat, and marks the first beat of each frame with a start flag. It distributes the beats into per-channel registers and presents each completed frame atomically to downstream logic through a valid/ack handshake. It sits between the serial digit source and the per-digit display/decode logic.

---
 rtl/tdm_digit_demux.sv | 104 ++++++++++
 tb/tb_tdm_digit_demux.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/tdm_digit_demux.sv
// Receive-side TDM digit demultiplexer: collects one beat per channel into a
// shadow buffer and publishes each complete frame atomically via valid/ack.
module tdm_digit_demux #(
    parameter int NUM_CH = 4,
    parameter int DW     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic [DW-1:0]        in_data,
    output logic                 in_ready,
    output logic [NUM_CH*DW-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ack,
    output logic                 frame_err
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;

    logic [1:0]                  r_state;
    logic [IW-1:0]               r_idx;
    logic [NUM_CH-1:0][DW-1:0]   r_shadow;
    logic [NUM_CH*DW-1:0]        r_out_data;
    logic                        r_out_valid;
    logic                        r_frame_err;

    logic                        w_ready;
    logic                        w_accept;
    logic                        w_drop;
    logic                        w_err;
    logic                        w_write;
    logic                        w_done;
    logic [IW-1:0]               w_widx;
    logic [NUM_CH-1:0][DW-1:0]   w_shadow_nxt;

    // Ready depends on state only, never on in_valid.
    assign w_ready  = (r_state != S_HOLD);
    assign w_accept = in_valid && w_ready;

    // An sof-less beat while idle has no frame to join and is discarded.
    assign w_drop  = w_accept && (r_state == S_IDLE) && !in_sof;
    assign w_err   = w_drop || (w_accept && (r_state == S_COLLECT) && in_sof);
    assign w_write = w_accept && !w_drop;
    assign w_widx  = in_sof ? '0 : r_idx;
    assign w_done  = w_write && (w_widx == LAST_IDX);

    // Shadow with the current beat merged, so completion can publish it in the same edge.
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (w_write) begin
            w_shadow_nxt[w_widx] = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_shadow    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_err;
            if (w_write) begin
                r_shadow <= w_shadow_nxt;
                r_idx    <= w_widx + IW'(1);
            end
            case (r_state)
                S_IDLE, S_COLLECT: begin
                    if (w_done) begin
                        r_out_data  <= w_shadow_nxt;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end else if (w_write) begin
                        r_state <= S_COLLECT;
                    end
                end
                S_HOLD: begin
                    if (out_ack) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_tdm_digit_demux.sv
// Directed bench for tdm_digit_demux: vector table for the main stream plus
// hand-written reset, back-to-back and min-period sequences.
module tb_tdm_digit_demux;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [3:0]  in_data = 4'h0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ack = 1'b0;
    logic        frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    tdm_digit_demux #(.NUM_CH(4), .DW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in_data(in_data), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ack(out_ack), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Inputs applied in this cycle, and outputs expected in this cycle before its edge.
    typedef struct {
        logic        v;
        logic        s;
        logic [3:0]  d;
        logic        a;
        logic        e_rdy;
        logic        e_vld;
        logic [15:0] e_data;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic rdy, input logic vld,
                            input logic [15:0] data, input logic err);
        chk({tag, ".in_ready"},  in_ready,  rdy);
        chk({tag, ".out_valid"}, out_valid, vld);
        chk({tag, ".out_data"},  out_data,  data);
        chk({tag, ".frame_err"}, frame_err, err);
    endtask

    // Present a beat until accepted (bounded), then take the accepting edge.
    task automatic send_beat(input logic sof, input logic [3:0] d, output int acc_cyc);
        int n;
        in_valid = 1'b1; in_sof = sof; in_data = d;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("send_beat.timeout", (n < 20), 1'b1);
        acc_cyc = cyc;
        step();
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, ".wait_valid"}, (n < 20), 1'b1);
    endtask

    initial begin
        int t0, t1, tmp;

        // Stream: nominal, back-pressure, short frame, orphan beat, gaps.
        //                 v  s  d     a  rdy vld data      err
        tbl.push_back('{1, 1, 4'h1, 0, 1, 0, 16'h0000, 0});
        tbl.push_back('{1, 0, 4'h2, 0, 1, 0, 16'h0000, 0});
        tbl.push_back('{1, 0, 4'h3, 0, 1, 0, 16'h0000, 0});
        tbl.push_back('{1, 0, 4'h4, 0, 1, 0, 16'h0000, 0});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{1, 1, 4'h5, 0, 0, 1, 16'h4321, 0});
        tbl.push_back('{1, 1, 4'h5, 1, 0, 1, 16'h4321, 0});
        tbl.push_back('{1, 1, 4'h5, 0, 1, 0, 16'h4321, 0});
        tbl.push_back('{1, 0, 4'h6, 0, 1, 0, 16'h4321, 0});
        tbl.push_back('{1, 0, 4'h7, 0, 1, 0, 16'h4321, 0});
        tbl.push_back('{1, 0, 4'h8, 0, 1, 0, 16'h4321, 0});
        tbl.push_back('{0, 0, 4'h0, 1, 0, 1, 16'h8765, 0});
        tbl.push_back('{1, 1, 4'h7, 0, 1, 0, 16'h8765, 0});
        tbl.push_back('{1, 0, 4'h8, 0, 1, 0, 16'h8765, 0});
        tbl.push_back('{1, 1, 4'h9, 0, 1, 0, 16'h8765, 0});
        tbl.push_back('{1, 0, 4'hA, 0, 1, 0, 16'h8765, 1});
        tbl.push_back('{1, 0, 4'hB, 0, 1, 0, 16'h8765, 0});
        tbl.push_back('{1, 0, 4'hC, 0, 1, 0, 16'h8765, 0});
        tbl.push_back('{0, 0, 4'h0, 1, 0, 1, 16'hCBA9, 0});
        tbl.push_back('{1, 0, 4'hF, 0, 1, 0, 16'hCBA9, 0});
        tbl.push_back('{0, 1, 4'h3, 0, 1, 0, 16'hCBA9, 1});
        tbl.push_back('{1, 1, 4'hD, 0, 1, 0, 16'hCBA9, 0});
        tbl.push_back('{1, 0, 4'hE, 0, 1, 0, 16'hCBA9, 0});
        tbl.push_back('{0, 1, 4'h9, 0, 1, 0, 16'hCBA9, 0});
        tbl.push_back('{1, 0, 4'h1, 0, 1, 0, 16'hCBA9, 0});
        tbl.push_back('{1, 0, 4'h2, 0, 1, 0, 16'hCBA9, 0});
        tbl.push_back('{0, 0, 4'h0, 1, 0, 1, 16'h21ED, 0});
        tbl.push_back('{0, 0, 4'h0, 1, 1, 0, 16'h21ED, 0});

        // Reset asserted mid-cycle, before any clock edge.
        #2 rst = 1'b1;
        #1 chk_outs("reset.immediate", 1, 0, 16'h0000, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_outs("reset.hold", 1, 0, 16'h0000, 0);
        end
        step();
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            in_valid = tbl[i].v; in_sof = tbl[i].s; in_data = tbl[i].d; out_ack = tbl[i].a;
            chk_outs($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_vld, tbl[i].e_data, tbl[i].e_err);
            step();
        end
        in_valid = 1'b0; in_sof = 1'b0; out_ack = 1'b0;

        // Reset mid-frame: partial 0x5,0x6 must not leak into the next frame.
        send_beat(1'b1, 4'h5, tmp);
        send_beat(1'b0, 4'h6, tmp);
        #3 rst = 1'b1;
        #1 chk_outs("midrst.immediate", 1, 0, 16'h0000, 0);
        step();
        rst = 1'b0;
        send_beat(1'b1, 4'hA, tmp);
        send_beat(1'b0, 4'hB, tmp);
        send_beat(1'b0, 4'hC, tmp);
        chk("midrst.no_early_valid", out_valid, 1'b0);
        send_beat(1'b0, 4'hD, tmp);
        chk_outs("midrst.frame", 0, 1, 16'hDCBA, 0);

        // Reset while holding a pending frame drops it.
        #3 rst = 1'b1;
        #1 chk_outs("holdrst.immediate", 1, 0, 16'h0000, 0);
        step();
        rst = 1'b0;

        // Minimum frame period with ack tied high: NUM_CH+1 cycles.
        out_ack = 1'b1;
        send_beat(1'b1, 4'h1, t0);
        send_beat(1'b0, 4'h2, tmp);
        send_beat(1'b0, 4'h3, tmp);
        send_beat(1'b0, 4'h4, tmp);
        chk_outs("minper.frame1", 0, 1, 16'h4321, 0);
        send_beat(1'b1, 4'h8, t1);
        chk("minper.period", t1 - t0, 5);
        send_beat(1'b0, 4'h9, tmp);
        send_beat(1'b0, 4'hA, tmp);
        send_beat(1'b0, 4'hB, tmp);
        wait_valid("minper");
        chk("minper.frame2", out_data, 16'hBA98);
        out_ack = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
